// File: rtl/fsm_share_arbiter.sv
// Shares one FSM-driven resource among N requesters with a registered one-hot grant,
// request/grant/done handshake, hold-time watchdog and fixed-priority or round-robin policy.
module fsm_share_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned IW       = 2,
  parameter int unsigned POLICY   = 0,
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CW       = 8
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] owner,
  output logic          busy,
  output logic          timeout
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StBusy    = 2'b01,
    StRelease = 2'b10
  } state_e;

  localparam logic [N-1:0]  One     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MaxHold = CW'(MAX_HOLD);
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic [IW-1:0] win;
  logic          found;
  int unsigned   cand;
  logic          owner_done;
  logic          owner_req;

  // Winner search: from index 0 under fixed priority, from the pointer (wrapping) under
  // round-robin. Bits are tested by mask so N need not be a power of two.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (POLICY == 1) ? (32'(ptr_q) + k) % N : k;
      if (!found && (|(req & (One << cand)))) begin
        found = 1'b1;
        win   = IW'(cand);
      end
    end
  end

  // gnt_q is the owner's one-hot mask while busy, so it selects the owner's bits directly.
  assign owner_done = |(done & gnt_q);
  assign owner_req  = |(req & gnt_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;

    case (state_q)
      StIdle: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (|req) begin
          state_d = StBusy;
          gnt_d   = One << win;
          owner_d = win;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end

      StBusy: begin
        cnt_d = (cnt_q == MaxHold) ? cnt_q : cnt_q + CW'(1);
        if (owner_done || !owner_req || (cnt_q == MaxHold)) begin
          state_d   = StRelease;
          gnt_d     = '0;
          busy_d    = 1'b0;
          cnt_d     = '0;
          timeout_d = !owner_done && owner_req;
        end
      end

      StRelease: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
        if (POLICY == 1) begin
          ptr_d = (owner_q == LastIdx) ? '0 : owner_q + IW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

  a_gnt_onehot0: assert property (@(posedge clock) disable iff (!reset_n) $onehot0(gnt));
  a_gnt_busy:    assert property (@(posedge clock) disable iff (!reset_n) ((gnt != '0) == busy));

endmodule

// File: tb/tb_fsm_share_arbiter.sv
// Bench for fsm_share_arbiter: a fixed-priority and a round-robin instance share stimulus,
// directed scenarios check hand-derived values, random traffic is checked against a model.
module tb_fsm_share_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned IW       = 2;
  localparam int unsigned MAX_HOLD = 15;
  localparam int unsigned CW       = 8;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  req     = '0;
  logic [N-1:0]  done    = '0;
  logic [N-1:0]  gnt_fp, gnt_rr;
  logic [IW-1:0] owner_fp, owner_rr;
  logic          busy_fp, busy_rr, to_fp, to_rr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  fsm_share_arbiter #(
    .N(N), .IW(IW), .POLICY(0), .MAX_HOLD(MAX_HOLD), .CW(CW)
  ) dut_fp (
    .clock(clock), .reset_n(reset_n), .req(req), .done(done),
    .gnt(gnt_fp), .owner(owner_fp), .busy(busy_fp), .timeout(to_fp)
  );

  fsm_share_arbiter #(
    .N(N), .IW(IW), .POLICY(1), .MAX_HOLD(MAX_HOLD), .CW(CW)
  ) dut_rr (
    .clock(clock), .reset_n(reset_n), .req(req), .done(done),
    .gnt(gnt_rr), .owner(owner_rr), .busy(busy_rr), .timeout(to_rr)
  );

  // Reference model, index 0 = fixed priority, 1 = round-robin. m_age counts cycles the
  // grant has been visible; the watchdog fires once it has been visible MAX_HOLD+1 cycles.
  bit            m_busy [2];
  bit            m_turn [2];
  bit            m_to   [2];
  int unsigned   m_age  [2];
  logic [IW-1:0] m_owner[2];
  logic [IW-1:0] m_ptr  [2];

  function automatic logic [IW-1:0] pick(input int p, input logic [N-1:0] r,
                                         input logic [IW-1:0] ptr);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (p == 1) ? (int'(ptr) + k) % N : k;
      if (r[i]) return IW'(i);
    end
    return '0;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    for (int p = 0; p < 2; p++) begin
      if (!reset_n) begin
        m_busy[p] <= 1'b0; m_turn[p] <= 1'b0; m_to[p] <= 1'b0;
        m_age[p] <= 0; m_owner[p] <= '0; m_ptr[p] <= '0;
      end else if (m_busy[p]) begin
        if (done[m_owner[p]] || !req[m_owner[p]]) begin
          m_busy[p] <= 1'b0; m_turn[p] <= 1'b1; m_to[p] <= 1'b0;
        end else if (m_age[p] == MAX_HOLD + 1) begin
          m_busy[p] <= 1'b0; m_turn[p] <= 1'b1; m_to[p] <= 1'b1;
        end else begin
          m_age[p] <= m_age[p] + 1;
        end
      end else if (m_turn[p]) begin
        m_turn[p] <= 1'b0;
        m_to[p]   <= 1'b0;
        if (p == 1) m_ptr[p] <= IW'((int'(m_owner[p]) + 1) % N);
      end else if (req != '0) begin
        m_owner[p] <= pick(p, req, m_ptr[p]);
        m_busy[p]  <= 1'b1;
        m_age[p]   <= 1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called just after an edge; pulses reset well clear of the next edge.
  task automatic apply_reset();
    reset_n = 1'b0;
    req     = '0;
    done    = '0;
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    n_tests++;
    if (gnt_fp !== 4'b0000 || busy_fp !== 1'b0 || owner_fp !== 2'd0 || to_fp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fp: gnt=%b busy=%b owner=%0d to=%b required 0000 0 0 0",
               gnt_fp, busy_fp, owner_fp, to_fp);
    end
    n_tests++;
    if (gnt_rr !== 4'b0000 || busy_rr !== 1'b0 || owner_rr !== 2'd0 || to_rr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rr: gnt=%b busy=%b owner=%0d to=%b required 0000 0 0 0",
               gnt_rr, busy_rr, owner_rr, to_rr);
    end
    tick();
    reset_n = 1'b1;
    req     = 4'b0100;
    tick();
    n_tests++;
    if (gnt_fp !== 4'b0100 || owner_fp !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_pre_grant: gnt=%b owner=%0d required 0100 2", gnt_fp, owner_fp);
    end
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (gnt_fp !== 4'b0000 || busy_fp !== 1'b0 || owner_fp !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async: gnt=%b busy=%b owner=%0d required 0000 0 0",
               gnt_fp, busy_fp, owner_fp);
    end
    reset_n = 1'b1;
    req     = 4'b0001;
    tick();
    n_tests++;
    if (gnt_fp !== 4'b0001 || gnt_rr !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_regrant: gnt_fp=%b gnt_rr=%b required 0001", gnt_fp, gnt_rr);
    end
  endtask

  task automatic test_fixed_priority();
    logic [IW-1:0] rr_order[3] = '{2'd1, 2'd3, 2'd1};
    apply_reset();
    req = 4'b1010;
    for (int g = 0; g < 3; g++) begin
      tick();
      n_tests++;
      if (gnt_fp !== 4'b0010 || owner_fp !== 2'd1) begin
        n_fail++;
        $display("FAIL fp_grant[%0d]: gnt=%b owner=%0d required 0010 1", g, gnt_fp, owner_fp);
      end
      n_tests++;
      if (owner_rr !== rr_order[g] || busy_rr !== 1'b1) begin
        n_fail++;
        $display("FAIL fp_rr_side[%0d]: owner=%0d busy=%b required %0d 1",
                 g, owner_rr, busy_rr, rr_order[g]);
      end
      done = 4'b1010;
      tick();
      done = '0;
      n_tests++;
      if (gnt_fp !== 4'b0000 || busy_fp !== 1'b0) begin
        n_fail++;
        $display("FAIL fp_release[%0d]: gnt=%b busy=%b required 0000 0", g, gnt_fp, busy_fp);
      end
      tick();
      n_tests++;
      if (gnt_fp !== 4'b0000) begin
        n_fail++;
        $display("FAIL fp_turnaround[%0d]: gnt=%b required 0000", g, gnt_fp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    apply_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp_g = 4'b0001 << (g % 4);
      tick();
      n_tests++;
      if (gnt_rr !== exp_g || owner_rr !== IW'(g % 4)) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: gnt=%b owner=%0d required %b %0d",
                 g, gnt_rr, owner_rr, exp_g, g % 4);
      end
      n_tests++;
      if (gnt_fp !== 4'b0001) begin
        n_fail++;
        $display("FAIL rr_fp_side[%0d]: gnt=%b required 0001", g, gnt_fp);
      end
      tick();
      tick();
      done = 4'b1111;
      tick();
      done = '0;
      n_tests++;
      if (gnt_rr !== 4'b0000 || busy_rr !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_release[%0d]: gnt=%b busy=%b required 0000 0", g, gnt_rr, busy_rr);
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    int high;
    int early;
    apply_reset();
    req   = 4'b0001;
    high  = 0;
    early = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (gnt_fp === 4'b0001) high++;
      if (to_fp !== 1'b0) early++;
    end
    n_tests++;
    if (high != 16 || early != 0) begin
      n_fail++;
      $display("FAIL wd_hold: high_cycles=%0d early_timeouts=%0d required 16 0", high, early);
    end
    tick();
    n_tests++;
    if (gnt_fp !== 4'b0000 || to_fp !== 1'b1 || to_rr !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_fire: gnt=%b to_fp=%b to_rr=%b required 0000 1 1", gnt_fp, to_fp, to_rr);
    end
    tick();
    n_tests++;
    if (to_fp !== 1'b0 || gnt_fp !== 4'b0000) begin
      n_fail++;
      $display("FAIL wd_pulse: to=%b gnt=%b required 0 0000", to_fp, gnt_fp);
    end
    tick();
    n_tests++;
    if (gnt_fp !== 4'b0001) begin
      n_fail++;
      $display("FAIL wd_regrant: gnt=%b required 0001", gnt_fp);
    end
  endtask

  task automatic test_collision();
    apply_reset();
    req = 4'b0001;
    repeat (16) tick();
    done = 4'b0001;
    tick();
    done = '0;
    n_tests++;
    if (gnt_fp !== 4'b0000 || busy_fp !== 1'b0 || to_fp !== 1'b0) begin
      n_fail++;
      $display("FAIL col_done_vs_wd: gnt=%b busy=%b to=%b required 0000 0 0",
               gnt_fp, busy_fp, to_fp);
    end
    tick();
    apply_reset();
    req = 4'b0010;
    tick();
    done = 4'b0100;
    tick();
    done = '0;
    n_tests++;
    if (gnt_fp !== 4'b0010 || busy_fp !== 1'b1) begin
      n_fail++;
      $display("FAIL col_foreign_done: gnt=%b busy=%b required 0010 1", gnt_fp, busy_fp);
    end
    tick();
    n_tests++;
    if (gnt_fp !== 4'b0010 || owner_fp !== 2'd1) begin
      n_fail++;
      $display("FAIL col_foreign_hold: gnt=%b owner=%0d required 0010 1", gnt_fp, owner_fp);
    end
  endtask

  task automatic test_withdrawal();
    apply_reset();
    req = 4'b1001;
    tick();
    n_tests++;
    if (gnt_fp !== 4'b0001) begin
      n_fail++;
      $display("FAIL wdr_grant: gnt=%b required 0001", gnt_fp);
    end
    tick();
    tick();
    req = 4'b1000;
    tick();
    n_tests++;
    if (gnt_fp !== 4'b0000 || busy_fp !== 1'b0 || to_fp !== 1'b0) begin
      n_fail++;
      $display("FAIL wdr_release: gnt=%b busy=%b to=%b required 0000 0 0",
               gnt_fp, busy_fp, to_fp);
    end
    tick();
    n_tests++;
    if (gnt_fp !== 4'b0000) begin
      n_fail++;
      $display("FAIL wdr_turnaround: gnt=%b required 0000", gnt_fp);
    end
    tick();
    n_tests++;
    if (gnt_fp !== 4'b1000 || owner_fp !== 2'd3 || gnt_rr !== 4'b1000) begin
      n_fail++;
      $display("FAIL wdr_pending: gnt_fp=%b owner=%0d gnt_rr=%b required 1000 3 1000",
               gnt_fp, owner_fp, gnt_rr);
    end
  endtask

  task automatic test_random();
    logic [N-1:0]  g, eg;
    logic [IW-1:0] o;
    logic          b, t;
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 15));
      done = ($urandom_range(0, 5) == 0) ? N'($urandom_range(1, 15)) : '0;
      @(negedge clock);
      for (int p = 0; p < 2; p++) begin
        g  = (p == 0) ? gnt_fp   : gnt_rr;
        o  = (p == 0) ? owner_fp : owner_rr;
        b  = (p == 0) ? busy_fp  : busy_rr;
        t  = (p == 0) ? to_fp    : to_rr;
        eg = m_busy[p] ? (4'b0001 << m_owner[p]) : 4'b0000;
        n_tests++;
        if (g !== eg || o !== m_owner[p] || b !== m_busy[p] || t !== m_to[p]) begin
          n_fail++;
          $display("FAIL rand[%0d] policy%0d: gnt=%b owner=%0d busy=%b to=%b required %b %0d %b %b",
                   c, p, g, o, b, t, eg, m_owner[p], m_busy[p], m_to[p]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_watchdog();
    test_collision();
    test_withdrawal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL sim_time_limit: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/fsm_share_arbiter.md
Name: fsm_share_arbiter

Overview:
- Shares one FSM-driven resource, such as a shared output register or case-decoded datapath, between N requesters. Only one requester owns the resource at a time.
- Grants are one-hot, with a request/grant/done handshake, a hold-time watchdog and a selectable arbitration policy.
- Sits between multiple FSM instances and the common resource they would otherwise drive concurrently.

Parameters:
- N, 4, number of requesters (2..8).
- IW, 2, width of owner index; must satisfy 2**IW >= N.
- POLICY, 0, arbitration policy: 0 = fixed priority (lowest index wins), 1 = round-robin.
- MAX_HOLD, 15, maximum cycles a grant is held in BUSY before forced release (1..255).
- CW, 8, hold counter width; must satisfy 2**CW > MAX_HOLD.

Ports:
- clock  input  1  single clock, all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector, one bit per requester; level-held until done.
- done  input  N  per-requester completion strobe; only the owner's bit is honoured.
- gnt  output  N  one-hot grant vector, registered.
- owner  output  IW  index of the current or last grantee, registered.
- busy  output  1  high while in BUSY.
- timeout  output  1  one-cycle pulse when a grant is force-released by the watchdog.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, gnt=0, owner=0, busy=0, timeout=0, hold counter=0, round-robin pointer=0. Takes effect immediately mid-grant; the grant drops without a RELEASE cycle.
- State encoding: IDLE=2'b00, BUSY=2'b01, RELEASE=2'b10. Encoding 2'b11 is illegal and returns to IDLE on the next edge.
- IDLE:
  - If req!=0 at an edge, select a winner w, set gnt=1<<w, owner=w, busy=1, counter=0, and go to BUSY. The grant is visible one cycle after the req sampling edge.
  - If req==0, outputs hold (gnt=0, owner unchanged).
- Winner selection:
  - POLICY=0: lowest set index of req.
  - POLICY=1: first set index searching upward from pointer, wrapping N-1 to 0.
- BUSY: the counter increments every cycle. Release conditions are evaluated in priority order:
  1. done[owner]=1 -> RELEASE, timeout=0.
  2. req[owner]=0 (requester withdrew) -> RELEASE, timeout=0.
  3. counter==MAX_HOLD -> RELEASE, timeout=1 for exactly one cycle.
  - On any transition to RELEASE: gnt=0 and busy=0 at the same edge.
  - done on any non-owner bit is ignored.
  - Changes to req of non-owners do not affect the grant.
- RELEASE: one turnaround cycle.
  - pointer=(owner+1) mod N under POLICY=1; the pointer is unused under POLICY=0.
  - timeout returns to 0.
  - Next state is IDLE unconditionally.
  - The earliest new grant is therefore 2 edges after the release edge.
- Simultaneous events:
  - done[owner] on the same edge the counter reaches MAX_HOLD: normal release, no timeout.
  - A requester re-asserting req during RELEASE is arbitrated normally in IDLE.
- Invariants: gnt is always zero or one-hot; gnt!=0 iff busy=1; owner is stable throughout BUSY.
- Counter saturates at MAX_HOLD; no wrap.

Test Plan:
- Reset: reset_n low mid-BUSY with gnt=4'b0100 -> gnt=0, busy=0, owner=0 immediately, before any clock edge; after release, req=4'b0001 -> gnt=4'b0001 one cycle later.
- Fixed priority (POLICY=0): req=4'b1010 held, done[owner] pulsed each grant -> grants 4'b0010 repeatedly; index 3 starves. Expect 2 idle cycles (RELEASE, IDLE) between grants.
- Round-robin (POLICY=1): req=4'b1111 held, done pulsed 3 cycles after each grant -> grant order 0,1,2,3,0; owner matches each grant.
- Watchdog: MAX_HOLD=15, req=4'b0001, no done -> gnt high for 16 cycles, then drops; timeout=1 for exactly that one edge; counter saturates without wrap.
- Collision: done[owner] on the cycle counter==MAX_HOLD -> release with timeout=0. done[2] pulsed while owner=1 -> ignored, gnt unchanged.
- Withdrawal: owner deasserts req at cycle 3 of BUSY with no done -> release next edge, timeout=0; a pending req=4'b1000 is granted 2 edges later.
